stim_player: RTL and testbench
==============================

STIM_PLAYER -- requirements
Module: stim_player

Interface
REQ-001 SHALL have parameter DW, default 32, stimulus payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, stimuli_valid low time after a do_reset record; >= 16, to cover the 15-cycle downstream reset window.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_valid  in  1  producer offers a record.
REQ-007 SHALL have port wr_ready  out  1  FIFO can accept a record.
REQ-008 SHALL have port wr_data  in  DW  record payload.
REQ-009 SHALL have port wr_do_reset  in  1  record requests a system reset when presented.
REQ-010 SHALL have port stimuli_valid  out  1  registered; record presented downstream.
REQ-011 SHALL have port stimuli_data  out  DW  registered payload.
REQ-012 SHALL have port do_reset  out  1  registered reset flag of presented record.
REQ-013 SHALL have port stimuli_ready  in  1  downstream accepts the presented record.
REQ-014 SHALL have port fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port busy  out  1  high when state != IDLE or fifo_count != 0.

Function
REQ-016 SHALL accept a write when wr_valid && wr_ready; wr_ready = (fifo_count < DEPTH), with no same-cycle pop bypass when full.
REQ-017 SHALL keep fifo_count unchanged on a simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-018 SHALL implement states IDLE, PRESENT and HOLD.
REQ-019 IDLE: if FIFO is non-empty, SHALL pop the head into stimuli_data/do_reset and go to PRESENT; stimuli_valid = 0 throughout IDLE.
REQ-020 PRESENT: SHALL hold stimuli_valid = 1 with data and do_reset stable until the cycle in which stimuli_ready = 1 (the handshake).
REQ-021 On a handshake at cycle T with do_reset = 0, SHALL go to IDLE; the next stimuli_valid rises no earlier than T+2.
REQ-022 On a handshake at cycle T with do_reset = 1, SHALL go to HOLD for exactly HOLD_CYCLES cycles, then IDLE; the next stimuli_valid rises no earlier than T+HOLD_CYCLES+2.
REQ-023 SHALL drop stimuli_valid for at least one cycle between consecutive records, so every record produces a rising edge.
REQ-024 Latency: SHALL raise stimuli_valid at N+2 for a record written at cycle N into an empty FIFO while in IDLE.
REQ-025 SHALL ignore stimuli_ready outside PRESENT.
REQ-026 In HOLD, SHALL continue accepting FIFO writes and SHALL NOT pop.

Reset
REQ-027 While reset = 1, SHALL force state IDLE, empty FIFO, fifo_count = 0, stimuli_valid = 0, stimuli_data = 0, do_reset = 0, busy = 0, HOLD counter = 0.
REQ-028 Reset asserted in PRESENT or HOLD SHALL abort immediately without a handshake; the record in flight and all queued records are discarded.
REQ-029 SHALL drive wr_ready = 0 during reset and wr_ready = 1 on the first cycle after reset deasserts.

Configuration
REQ-030 With STIM_PLAYER_COUNT_EN defined, SHALL add port stim_count  out  32, reset to 0, incremented on each downstream handshake, wrapping 0xFFFFFFFF -> 0.
REQ-031 Without STIM_PLAYER_COUNT_EN, SHALL omit the stim_count port and its logic; all other behaviour is identical.

Verification
REQ-032 Write 0xA5A5A5A5 (do_reset = 0) at cycle 10 with stimuli_ready tied high -> stimuli_valid = 1 at cycle 12 only, data 0xA5A5A5A5.
REQ-033 Write 3 records back-to-back with stimuli_ready high -> 3 valid pulses, each followed by >= 1 low cycle, data in write order.
REQ-034 Write record R1 (do_reset = 1) then R2, handshake R1 at T -> stimuli_valid low T+1..T+17, R2 valid at T+18 (HOLD_CYCLES = 16).
REQ-035 Write 17 records with stimuli_ready low -> wr_ready = 0 after 16 writes, fifo_count = 16; the 17th write is held until a pop.
REQ-036 Assert reset in PRESENT with 5 queued records -> next cycle stimuli_valid = 0, fifo_count = 0, busy = 0.
REQ-037 With STIM_PLAYER_COUNT_EN defined and stim_count forced to 0xFFFFFFFF, one handshake -> stim_count = 0.

Source files
------------

// File: rtl/stim_player.sv
// -----------------------------------------------------------------------------
// stim_player
//
// Stimulus player. A producer writes records (a payload plus a "do_reset"
// flag) into a small FIFO. Each record is presented downstream one at a time
// through a valid/ready handshake. stimuli_valid always drops for at least one
// cycle between records, so every record gives downstream a rising edge.
//
// A record whose do_reset flag is set asks for a downstream system reset.
// After its handshake the player waits HOLD_CYCLES cycles before it presents
// anything else, which covers the downstream reset window. While it waits it
// still accepts writes into the FIFO.
//
// Parameters:
//   DW          stimulus payload width in bits
//   DEPTH       FIFO entries; must be a power of two and at least 2
//   HOLD_CYCLES cycles stimuli_valid stays low after a do_reset handshake
//               (at least 16)
//
// Optional feature:
//   STIM_PLAYER_COUNT_EN  When defined, adds a 32-bit stim_count output. It
//                         counts downstream handshakes and wraps to 0.
//
// Ports:
//   clk            sole clock; all logic runs on its rising edge
//   reset          synchronous, active-high reset
//   wr_valid       producer offers a record
//   wr_ready       FIFO can accept a record (low while reset is high)
//   wr_data        record payload
//   wr_do_reset    record requests a downstream reset when it is presented
//   stimuli_valid  registered; a record is being presented downstream
//   stimuli_data   registered payload of the presented record
//   do_reset       registered reset flag of the presented record
//   stimuli_ready  downstream accepts the presented record
//   fifo_count     current FIFO occupancy
//   busy           high while the player is not idle or the FIFO holds data
//   stim_count     (STIM_PLAYER_COUNT_EN only) downstream handshake count
// -----------------------------------------------------------------------------
module stim_player #(
   parameter int DW          = 32,
   parameter int DEPTH       = 16,
   parameter int HOLD_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [DW-1:0]          wr_data,
   input  logic                   wr_do_reset,
   output logic                   stimuli_valid,
   output logic [DW-1:0]          stimuli_data,
   output logic                   do_reset,
   input  logic                   stimuli_ready,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy
`ifdef STIM_PLAYER_COUNT_EN
   ,
   output logic [31:0]            stim_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(HOLD_CYCLES) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t          state_reg, state_next;
   logic [HW-1:0]   hold_reg, hold_next;

   // FIFO storage. Bit DW carries the do_reset flag next to the payload.
   logic [DW:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;

   logic            stimuli_valid_reg;
   logic [DW-1:0]   stimuli_data_reg;
   logic            do_reset_reg;

   logic            push;
   logic            pop;
   logic            handshake;
   logic            fifo_full;
   logic            fifo_empty;

   assign fifo_full  = (count_reg == CW'(DEPTH));
   assign fifo_empty = (count_reg == '0);

   // wr_ready looks only at occupancy. A pop in the same cycle does not free
   // a slot for a write while the FIFO is full. Reset holds wr_ready low so
   // the producer never sees a write get lost.
   assign wr_ready = ~reset & ~fifo_full;
   assign push     = wr_valid & wr_ready;

   // ---------------------------------------------------------------------
   // Next-state / control
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      pop        = 1'b0;
      handshake  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = PRESENT;
            end
         end

         PRESENT: begin
            if (stimuli_ready) begin
               handshake = 1'b1;
               if (do_reset_reg) begin
                  // Load HOLD_CYCLES-1 so that HOLD lasts exactly
                  // HOLD_CYCLES cycles, counting down to zero.
                  hold_next  = HW'(HOLD_CYCLES - 1);
                  state_next = HOLD;
               end else begin
                  state_next = IDLE;
               end
            end
         end

         HOLD: begin
            if (hold_reg == '0) begin
               state_next = IDLE;
            end else begin
               hold_next = hold_reg - HW'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FIFO write port. The array has no reset so it can map onto block RAM.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {wr_do_reset, wr_data};
      end
   end

   // ---------------------------------------------------------------------
   // Control registers and registered FIFO read
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg         <= IDLE;
         hold_reg          <= '0;
         wr_ptr_reg        <= '0;
         rd_ptr_reg        <= '0;
         count_reg         <= '0;
         stimuli_valid_reg <= 1'b0;
         stimuli_data_reg  <= '0;
         do_reset_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         hold_reg  <= hold_next;

         // DEPTH is a power of two, so the pointers wrap on their own.
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg       <= rd_ptr_reg + AW'(1);
            stimuli_data_reg <= mem[rd_ptr_reg][DW-1:0];
            do_reset_reg     <= mem[rd_ptr_reg][DW];
         end

         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase

         // Valid follows PRESENT exactly. Every exit from PRESENT passes
         // through IDLE or HOLD, so valid drops for at least one cycle
         // between records.
         stimuli_valid_reg <= (state_next == PRESENT);
      end
   end

`ifdef STIM_PLAYER_COUNT_EN
   logic [31:0] stim_count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         stim_count_reg <= '0;
      end else if (handshake) begin
         stim_count_reg <= stim_count_reg + 32'd1;
      end
   end

   assign stim_count = stim_count_reg;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign stimuli_valid = stimuli_valid_reg;
   assign stimuli_data  = stimuli_data_reg;
   assign do_reset      = do_reset_reg;
   assign fifo_count    = count_reg;
   assign busy          = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_stim_player.sv
// -----------------------------------------------------------------------------
// tb_stim_player
//
// Directed testbench for stim_player with the default parameters
// (DW=32, DEPTH=16, HOLD_CYCLES=16). Inputs change 1 time unit after a rising
// edge, and outputs are checked at that same point. After each tick() the
// bench is therefore one cycle further on, and the checks see the registered
// state of that cycle.
// -----------------------------------------------------------------------------
module tb_stim_player;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] wr_data;
   logic          wr_do_reset;
   logic          stimuli_valid;
   logic [DW-1:0] stimuli_data;
   logic          do_reset;
   logic          stimuli_ready;
   logic [4:0]    fifo_count;
   logic          busy;
`ifdef STIM_PLAYER_COUNT_EN
   logic [31:0]   stim_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stim_player #(
      .DW(DW),
      .DEPTH(16),
      .HOLD_CYCLES(16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .wr_do_reset  (wr_do_reset),
      .stimuli_valid(stimuli_valid),
      .stimuli_data (stimuli_data),
      .do_reset     (do_reset),
      .stimuli_ready(stimuli_ready),
      .fifo_count   (fifo_count),
      .busy         (busy)
`ifdef STIM_PLAYER_COUNT_EN
      ,
      .stim_count   (stim_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [31:0] recs [3];
   logic        exp_v [7];
   int          exp_idx [7];

   initial begin
      reset         = 1'b1;
      wr_valid      = 1'b0;
      wr_data       = '0;
      wr_do_reset   = 1'b0;
      stimuli_ready = 1'b0;

      // ---------------- reset state ----------------
      tick(); tick(); tick();
      chk("rst_valid",   64'(stimuli_valid), 64'd0);
      chk("rst_data",    64'(stimuli_data),  64'd0);
      chk("rst_doreset", 64'(do_reset),      64'd0);
      chk("rst_count",   64'(fifo_count),    64'd0);
      chk("rst_busy",    64'(busy),          64'd0);
      chk("rst_wrready", 64'(wr_ready),      64'd0);
      $display("reset held: valid=%0d count=%0d busy=%0d wr_ready=%0d",
               stimuli_valid, fifo_count, busy, wr_ready);

      reset = 1'b0;
      tick();
      chk("post_rst_wrready", 64'(wr_ready), 64'd1);

      // ---------------- single record, latency N+2 ----------------
      stimuli_ready = 1'b1;
      wr_valid = 1'b1; wr_data = 32'hA5A5_A5A5; wr_do_reset = 1'b0;
      tick();                                   // cycle N+1
      wr_valid = 1'b0;
      chk("lat_n1_valid", 64'(stimuli_valid), 64'd0);
      chk("lat_n1_count", 64'(fifo_count),    64'd1);
      chk("lat_n1_busy",  64'(busy),          64'd1);
      tick();                                   // cycle N+2
      chk("lat_n2_valid", 64'(stimuli_valid), 64'd1);
      chk("lat_n2_data",  64'(stimuli_data),  64'hA5A5_A5A5);
      chk("lat_n2_dorst", 64'(do_reset),      64'd0);
      $display("single: valid=%0d data=%08h at N+2", stimuli_valid, stimuli_data);
      tick();                                   // cycle N+3
      chk("lat_n3_valid", 64'(stimuli_valid), 64'd0);
      tick();
      chk("lat_idle_busy", 64'(busy), 64'd0);

      // ---------------- three records back-to-back ----------------
      recs[0] = 32'h1111_0001; recs[1] = 32'h2222_0002; recs[2] = 32'h3333_0003;
      exp_v[0] = 0; exp_v[1] = 1; exp_v[2] = 0; exp_v[3] = 1;
      exp_v[4] = 0; exp_v[5] = 1; exp_v[6] = 0;
      exp_idx[0] = 0; exp_idx[1] = 0; exp_idx[2] = 0; exp_idx[3] = 1;
      exp_idx[4] = 0; exp_idx[5] = 2; exp_idx[6] = 0;
      for (int i = 0; i < 7; i++) begin
         if (i < 3) begin
            wr_valid = 1'b1; wr_data = recs[i];
         end else begin
            wr_valid = 1'b0;
         end
         tick();
         chk($sformatf("b2b_valid_%0d", i), 64'(stimuli_valid), 64'(exp_v[i]));
         if (exp_v[i]) begin
            chk($sformatf("b2b_data_%0d", i), 64'(stimuli_data), 64'(recs[exp_idx[i]]));
         end
         $display("b2b step %0d: valid=%0d data=%08h", i, stimuli_valid, stimuli_data);
      end

      // ---------------- do_reset record then HOLD ----------------
      wr_valid = 1'b1; wr_data = 32'h0000_0111; wr_do_reset = 1'b1;
      tick();
      wr_data = 32'h0000_0222; wr_do_reset = 1'b0;
      tick();                                   // cycle T (handshake R1)
      wr_valid = 1'b0;
      chk("hold_t_valid", 64'(stimuli_valid), 64'd1);
      chk("hold_t_data",  64'(stimuli_data),  64'h111);
      chk("hold_t_dorst", 64'(do_reset),      64'd1);
      for (int k = 1; k <= 17; k++) begin
         tick();
         chk($sformatf("hold_low_T+%0d", k), 64'(stimuli_valid), 64'd0);
         chk($sformatf("hold_busy_T+%0d", k), 64'(busy), 64'd1);
      end
      tick();                                   // cycle T+18
      chk("hold_t18_valid", 64'(stimuli_valid), 64'd1);
      chk("hold_t18_data",  64'(stimuli_data),  64'h222);
      chk("hold_t18_dorst", 64'(do_reset),      64'd0);
      $display("hold: R2 valid=%0d data=%08h at T+18", stimuli_valid, stimuli_data);
      tick();
      chk("hold_t19_valid", 64'(stimuli_valid), 64'd0);
      tick();

      // ---------------- fill the FIFO with downstream stalled ----------------
      // Record 0 moves straight into the presentation register, so 17 writes
      // leave 16 entries queued.
      stimuli_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         wr_valid = 1'b1; wr_data = 32'h100 + 32'(i);
         chk($sformatf("fill_wrready_%0d", i), 64'(wr_ready), 64'd1);
         tick();
      end
      wr_data = 32'h1FF;                        // extra write, must be held
      chk("full_count",   64'(fifo_count),    64'd16);
      chk("full_wrready", 64'(wr_ready),      64'd0);
      chk("full_valid",   64'(stimuli_valid), 64'd1);
      chk("full_data",    64'(stimuli_data),  64'h100);
      $display("full: count=%0d wr_ready=%0d", fifo_count, wr_ready);
      tick();
      chk("full_hold_count",   64'(fifo_count), 64'd16);
      chk("full_hold_wrready", 64'(wr_ready),   64'd0);
      stimuli_ready = 1'b1;                     // handshake record 0x100
      tick();                                   // IDLE, pop happens here
      stimuli_ready = 1'b0;
      chk("pop_idle_valid",   64'(stimuli_valid), 64'd0);
      chk("pop_idle_count",   64'(fifo_count),    64'd16);
      chk("pop_idle_wrready", 64'(wr_ready),      64'd0);
      tick();                                   // slot free, held write lands
      chk("pop_next_valid",   64'(stimuli_valid), 64'd1);
      chk("pop_next_data",    64'(stimuli_data),  64'h101);
      chk("pop_next_count",   64'(fifo_count),    64'd15);
      chk("pop_next_wrready", 64'(wr_ready),      64'd1);
      tick();
      wr_valid = 1'b0;
      chk("refill_count", 64'(fifo_count), 64'd16);

      // ---------------- reset during PRESENT with a full queue ----------------
      chk("pre_abort_valid", 64'(stimuli_valid), 64'd1);
      reset = 1'b1;
      tick();
      chk("abort_valid",   64'(stimuli_valid), 64'd0);
      chk("abort_count",   64'(fifo_count),    64'd0);
      chk("abort_busy",    64'(busy),          64'd0);
      chk("abort_data",    64'(stimuli_data),  64'd0);
      chk("abort_wrready", 64'(wr_ready),      64'd0);
      $display("abort: valid=%0d count=%0d busy=%0d", stimuli_valid, fifo_count, busy);
      reset = 1'b0;
      tick();
      chk("abort_rel_wrready", 64'(wr_ready), 64'd1);
      tick(); tick();
      chk("abort_discard_valid", 64'(stimuli_valid), 64'd0);
      chk("abort_discard_busy",  64'(busy),          64'd0);

`ifdef STIM_PLAYER_COUNT_EN
      // ---------------- handshake counter wrap ----------------
      force dut.stim_count_reg = 32'hFFFF_FFFF;
      tick();
      release dut.stim_count_reg;
      chk("cnt_forced", 64'(stim_count), 64'hFFFF_FFFF);
      stimuli_ready = 1'b1;
      wr_valid = 1'b1; wr_data = 32'hCAFE; wr_do_reset = 1'b0;
      tick();
      wr_valid = 1'b0;
      tick();                                   // handshake cycle
      tick();
      chk("cnt_wrap", 64'(stim_count), 64'd0);
      $display("count wrap: stim_count=%08h", stim_count);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
